screen_controller: RTL and testbench
====================================

// Module: screen_controller
// PURPOSE
//  Game-screen sequencer and pixel-layer arbiter for Breakout.
//  - FSM steps IDLE -> SERVE -> PLAY -> OVER and tracks lives and win/lose.
//  - Gates paddle/ball motion via play_enable.
//  - Blinks the game-over overlay.
//  - Selects per pixel between the overlay layer and the game layer; drives the final VGA RGB.
// PARAMETERS
//  LIVES_INIT        3    lives loaded in IDLE (1..7)
//  SERVE_FRAMES      60   frames held in SERVE before PLAY (>=1)
//  BLINK_FRAMES      30   frames per overlay blink half-period (>=1)
//  OVER_HOLD_FRAMES  120  minimum frames in OVER before start is honoured (>=1)
//  H_ACTIVE          640  visible width (pixels)
//  V_ACTIVE          480  visible height (lines)
// PORTS
//  clock           in   1   system/pixel clock
//  reset           in   1   synchronous, active-high
//  pixel_x         in   10  current scan column
//  pixel_y         in   10  current scan row
//  start_btn       in   1   start button, level, already synchronised
//  ball_lost       in   1   1-cycle pulse: ball fell below paddle
//  bricks_cleared  in   1   1-cycle pulse: last brick destroyed
//  game_rgb        in   24  game layer {r,g,b}, 1-cycle registered vs pixel_x/y
//  game_active     in   1   game layer pixel valid, same timing as game_rgb
//  over_rgb        in   24  game-over overlay {r,g,b}, same timing
//  over_active     in   1   overlay pixel valid, same timing
//  red/green/blue  out  8   final colour, registered
//  play_enable     out  1   1 only in PLAY
//  lives           out  3   remaining lives
//  win             out  1   1 = OVER entered via bricks_cleared
//  state           out  2   IDLE=0 SERVE=1 PLAY=2 OVER=3
//  frame_tick      out  1   1-cycle pulse per frame
// BEHAVIOUR
//  Reset
//   - Next edge: state=IDLE; lives=LIVES_INIT; win=0; play_enable=0; frame_tick=0; RGB=0.
//   - All frame counters, blink phase and start_q cleared.
//   - Reset mid-game aborts to IDLE with no residual count.
//  Frame tick
//   - frame_tick registered, high one cycle after pixel_x==0 && pixel_y==V_ACTIVE.
//   - Exactly one pulse per frame.
//  Start edge
//   - start_q registered each cycle; start_rise = start_btn & ~start_q.
//   - A held button never retriggers.
//  FSM transitions
//   - IDLE: lives=LIVES_INIT, win=0. start_rise -> SERVE, frame count cleared.
//   - SERVE: count frame_ticks. On the SERVE_FRAMES-th tick -> PLAY.
//   - PLAY: bricks_cleared -> OVER, win=1.
//   - PLAY: else ball_lost with lives==1 -> OVER, lives=0, win=0.
//   - PLAY: else ball_lost -> lives-1, then SERVE.
//   - Both pulses in one cycle: bricks_cleared wins; no decrement.
//   - OVER: count frame_ticks, saturating at OVER_HOLD_FRAMES.
//   - OVER: start_rise before hold expiry ignored. After expiry, start_rise -> IDLE.
//   - Pulses outside PLAY are ignored.
//  Blink
//   - blink_on=1 on OVER entry.
//   - Toggles every BLINK_FRAMES frame_ticks while in OVER.
//   - Forced to 1 outside OVER.
//  Layer mux (registered; 1 cycle after the layer inputs, 2 after pixel_x/y)
//   - pixel_x/y delayed one cycle to align with the layer inputs.
//   - Delayed x>=H_ACTIVE or y>=V_ACTIVE -> RGB=0.
//   - Else state==OVER && over_active && blink_on -> over_rgb.
//   - Else game_active -> game_rgb.
//   - Else 0.
//   - Overlay is never shown outside OVER.
//  Widths
//   - Counters sized $clog2(max frames param + 1).
//   - lives compares are unsigned 3-bit; never underflows below 0.
// STRUCTURE
//  - breakout_pkg: state encodings, H_ACTIVE/V_ACTIVE defaults, RGB width (24).
//  - Sub-module frame_timer: tick-counting down-counter.
//    - Inputs: clear, tick. Output: done.
//    - Parameterised load value; used for SERVE, blink and OVER hold.
//  - FSM, lives register and layer mux stay in screen_controller.
// TESTING (SERVE_FRAMES=2, BLINK_FRAMES=2, OVER_HOLD_FRAMES=3, LIVES_INIT=3)
//  1. Reset, then start_btn held 10 cycles.
//     -> One SERVE entry; PLAY after 2nd frame_tick; play_enable=1.
//  2. Three ball_lost pulses in PLAY, each followed by serve.
//     -> lives 2,1 via SERVE; third -> OVER, lives=0, win=0.
//  3. ball_lost + bricks_cleared in the same cycle.
//     -> OVER, win=1, lives unchanged (3).
//  4. OVER, start_rise at frame 1, then again at frame 4.
//     -> First ignored; second -> IDLE with lives=3.
//  5. OVER, over_active=1, over_rgb=FFFFFF, game_rgb=123456, visible pixel.
//     -> RGB alternates FFFFFF / 123456 every 2 frames.
//     -> Same inputs in PLAY -> 123456 always.
//     -> pixel_x=700 -> 000000.
//  6. Reset asserted mid-SERVE and mid-OVER.
//     -> Next edge: IDLE, RGB=0, play_enable=0, counters cleared.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout screen sequencer: state encodings,
// default visible area, colour width and a counter-width helper.
package breakout_pkg;

    localparam int RGB_W        = 24;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick down-counter. Loads LOAD on clear, decrements once per tick.
// done is high on the tick that reaches terminal count and, when not
// reloading, stays high while the count sits at zero (saturated).
// With RELOAD set the counter reloads on terminal count, so done is a
// one-cycle pulse every LOAD ticks.
module frame_timer
    import breakout_pkg::*;
#(
    parameter int LOAD   = 1,
    parameter bit RELOAD = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int            CW     = cnt_width(LOAD);
    localparam logic [CW-1:0] LOAD_V = CW'(LOAD);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count;
    logic          terminal;

    assign terminal = tick && (count == ONE);
    assign done     = terminal || (count == '0);

    // Count down on ticks; reload on clear or (optionally) on terminal count.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= LOAD_V;
        end else if (terminal && RELOAD) begin
            count <= LOAD_V;
        end else if (tick && (count != '0)) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/screen_controller.sv
// Breakout screen sequencer and pixel-layer arbiter.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | attract screen, lives reloaded, waiting for a start press
//  SERVE | ball parked, counting SERVE_FRAMES frames before play
//  PLAY  | motion enabled, watching ball_lost / bricks_cleared
//  OVER  | game over, overlay blinking, start honoured after hold time
module screen_controller
    import breakout_pkg::*;
#(
    parameter int LIVES_INIT       = 3,
    parameter int SERVE_FRAMES     = 60,
    parameter int BLINK_FRAMES     = 30,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int H_ACTIVE         = H_ACTIVE_DEF,
    parameter int V_ACTIVE         = V_ACTIVE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             start_btn,
    input  logic             ball_lost,
    input  logic             bricks_cleared,
    input  logic [RGB_W-1:0] game_rgb,
    input  logic             game_active,
    input  logic [RGB_W-1:0] over_rgb,
    input  logic             over_active,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             play_enable,
    output logic [2:0]       lives,
    output logic             win,
    output logic [1:0]       state,
    output logic             frame_tick
);

    localparam logic [2:0] LIVES_V = 3'(LIVES_INIT);
    localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         lives_q;
    logic               win_q;
    logic               start_q;
    logic               start_rise;
    logic               match;
    logic               match_q;
    logic               frame_tick_q;
    logic               serve_done;
    logic               hold_done;
    logic               blink_done;
    logic               blink_on;
    logic [9:0]         px_q;
    logic [9:0]         py_q;
    logic [RGB_W-1:0]   rgb_q;

    assign start_rise = start_btn & ~start_q;
    assign match      = (pixel_x == 10'd0) && (pixel_y == V_LIM);

    // Frame tick fires once on the first cycle the scan reaches the
    // frame-end position, even if that position is held for several cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            match_q      <= match;
            frame_tick_q <= match & ~match_q;
            start_q      <= start_btn;
        end
    end

    frame_timer #(.LOAD(SERVE_FRAMES), .RELOAD(1'b0)) u_serve_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_q != ST_SERVE),
        .tick  (frame_tick_q),
        .done  (serve_done)
    );

    frame_timer #(.LOAD(OVER_HOLD_FRAMES), .RELOAD(1'b0)) u_hold_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_q != ST_OVER),
        .tick  (frame_tick_q),
        .done  (hold_done)
    );

    frame_timer #(.LOAD(BLINK_FRAMES), .RELOAD(1'b1)) u_blink_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_q != ST_OVER),
        .tick  (frame_tick_q),
        .done  (blink_done)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bricks_cleared outranks ball_lost in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (serve_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bricks_cleared) begin
                    state_d = ST_OVER;
                end else if (ball_lost) begin
                    state_d = (lives_q <= 3'd1) ? ST_OVER : ST_SERVE;
                end
            end
            ST_OVER: begin
                if (hold_done && start_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state and the registered datapath.
    always_comb begin
        play_enable = (state_q == ST_PLAY);
        state       = state_q;
        lives       = lives_q;
        win         = win_q;
        frame_tick  = frame_tick_q;
        red         = rgb_q[23:16];
        green       = rgb_q[15:8];
        blue        = rgb_q[7:0];
    end

    // Lives and win flag; lives stop at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            lives_q <= LIVES_V;
            win_q   <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            lives_q <= LIVES_V;
            win_q   <= 1'b0;
        end else if (state_q == ST_PLAY) begin
            if (bricks_cleared) begin
                win_q <= 1'b1;
            end else if (ball_lost && (lives_q != 3'd0)) begin
                lives_q <= lives_q - 3'd1;
                if (lives_q == 3'd1) win_q <= 1'b0;
            end
        end
    end

    // Blink phase: held on outside OVER, toggles each blink period inside.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_on <= 1'b1;
        end else if (state_q != ST_OVER) begin
            blink_on <= 1'b1;
        end else if (blink_done) begin
            blink_on <= ~blink_on;
        end
    end

    // Delay the scan position one cycle to line up with the layer inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= pixel_x;
            py_q <= pixel_y;
        end
    end

    // Layer mux: blank outside the visible area, overlay only in OVER.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q <= '0;
        end else if ((px_q >= H_LIM) || (py_q >= V_LIM)) begin
            rgb_q <= '0;
        end else if ((state_q == ST_OVER) && over_active && blink_on) begin
            rgb_q <= over_rgb;
        end else if (game_active) begin
            rgb_q <= game_rgb;
        end else begin
            rgb_q <= '0;
        end
    end

endmodule

// File: tb/tb_screen_controller.sv
// Bench for screen_controller with short frame parameters. Frames are
// produced by parking the scan at the frame-end position for a few cycles.
module tb_screen_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        start_btn, ball_lost, bricks_cleared;
    logic [23:0] game_rgb, over_rgb;
    logic        game_active, over_active;
    logic [7:0]  red, green, blue;
    logic        play_enable, win, frame_tick;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic [23:0] rgb;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3;

    always #5 clock = ~clock;
    assign rgb = {red, green, blue};

    screen_controller #(
        .LIVES_INIT(3), .SERVE_FRAMES(2), .BLINK_FRAMES(2), .OVER_HOLD_FRAMES(3),
        .H_ACTIVE(640), .V_ACTIVE(480)
    ) dut (
        .clock(clock), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .start_btn(start_btn), .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
        .game_rgb(game_rgb), .game_active(game_active),
        .over_rgb(over_rgb), .over_active(over_active),
        .red(red), .green(green), .blue(blue), .play_enable(play_enable),
        .lives(lives), .win(win), .state(state), .frame_tick(frame_tick)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One frame: frame-end position held 3 cycles, then back to a visible pixel.
    task automatic frame();
        int pulses = 0;
        pixel_x = 10'd0; pixel_y = 10'd480;
        repeat (3) begin step(); if (frame_tick === 1'b1) pulses++; end
        pixel_x = 10'd100; pixel_y = 10'd100;
        repeat (3) begin step(); if (frame_tick === 1'b1) pulses++; end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL frame_tick_count: got %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(); start_btn = 1'b0; step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(2);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected 0", state); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d, expected 3", lives); end
        checks++; if (win !== 1'b0 || play_enable !== 1'b0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_flags: win=%b play_enable=%b frame_tick=%b, expected 0 0 0", win, play_enable, frame_tick);
        end
        checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h, expected 000000", rgb); end
        reset = 1'b0; step();
    endtask

    task automatic test_start_held();
        int entries = 0;
        logic [1:0] prev;
        prev = state;
        start_btn = 1'b1;
        repeat (10) begin
            step();
            if (prev !== S_SERVE && state === S_SERVE) entries++;
            prev = state;
        end
        start_btn = 1'b0; step();
        checks++; if (entries !== 1) begin errors++; $display("FAIL serve_entries: got %0d, expected 1", entries); end
        checks++; if (state !== S_SERVE) begin errors++; $display("FAIL held_start_state: got %0d, expected 1", state); end
        ball_lost = 1'b1; step(); ball_lost = 1'b0; step();
        checks++; if (lives !== 3'd3 || state !== S_SERVE) begin
            errors++; $display("FAIL pulse_outside_play: lives=%0d state=%0d, expected 3 1", lives, state);
        end
        frame();
        checks++; if (state !== S_SERVE || play_enable !== 1'b0) begin
            errors++; $display("FAIL serve_after_1_frame: state=%0d play_enable=%b, expected 1 0", state, play_enable);
        end
        frame();
        checks++; if (state !== S_PLAY || play_enable !== 1'b1) begin
            errors++; $display("FAIL play_after_2_frames: state=%0d play_enable=%b, expected 2 1", state, play_enable);
        end
    endtask

    task automatic test_ball_lost();
        logic [2:0] exp_l;
        for (int i = 0; i < 3; i++) begin
            ball_lost = 1'b1; step(); ball_lost = 1'b0;
            if (i < 2) begin
                exp_l = 3'(2 - i);
                checks++; if (state !== S_SERVE || lives !== exp_l) begin
                    errors++; $display("FAIL ball_lost_%0d: state=%0d lives=%0d, expected 1 %0d", i, state, lives, exp_l);
                end
                frame(); frame();
                checks++; if (state !== S_PLAY) begin
                    errors++; $display("FAIL reserve_%0d: state=%0d, expected 2", i, state);
                end
            end else begin
                checks++; if (state !== S_OVER || lives !== 3'd0 || win !== 1'b0 || play_enable !== 1'b0) begin
                    errors++; $display("FAIL last_life: state=%0d lives=%0d win=%b pe=%b, expected 3 0 0 0", state, lives, win, play_enable);
                end
            end
        end
    endtask

    task automatic test_over_restart();
        frame();
        press_start();
        checks++; if (state !== S_OVER) begin errors++; $display("FAIL early_start: state=%0d, expected 3", state); end
        frame(); frame(); frame();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL late_start: state=%0d, expected 0", state); end
        step(2);
        checks++; if (lives !== 3'd3 || win !== 1'b0) begin
            errors++; $display("FAIL idle_reload: lives=%0d win=%b, expected 3 0", lives, win);
        end
    endtask

    task automatic test_both_pulses();
        press_start();
        frame(); frame();
        checks++; if (state !== S_PLAY) begin errors++; $display("FAIL both_setup: state=%0d, expected 2", state); end
        ball_lost = 1'b1; bricks_cleared = 1'b1; step();
        ball_lost = 1'b0; bricks_cleared = 1'b0;
        checks++; if (state !== S_OVER || win !== 1'b1 || lives !== 3'd3) begin
            errors++; $display("FAIL both_pulses: state=%0d win=%b lives=%0d, expected 3 1 3", state, win, lives);
        end
    endtask

    task automatic test_blink();
        logic [23:0] e;
        game_rgb = 24'h123456; game_active = 1'b1;
        over_rgb = 24'hFFFFFF; over_active = 1'b1;
        pixel_x = 10'd100; pixel_y = 10'd100;
        exp_q.push_back(24'hFFFFFF);
        step(3);
        e = exp_q.pop_front();
        checks++; if (rgb !== e) begin errors++; $display("FAIL blink_entry: got %h, expected %h", rgb, e); end
        for (int k = 1; k <= 6; k++) begin
            frame();
            exp_q.push_back((((k / 2) % 2) == 0) ? 24'hFFFFFF : 24'h123456);
            step();
            e = exp_q.pop_front();
            checks++; if (rgb !== e) begin errors++; $display("FAIL blink_frame_%0d: got %h, expected %h", k, rgb, e); end
        end
        checks++; if (state !== S_OVER) begin errors++; $display("FAIL blink_state: got %0d, expected 3", state); end
    endtask

    task automatic test_reset_mid();
        checks++; if (rgb === 24'h0) begin errors++; $display("FAIL pre_reset_rgb: got %h, expected nonzero", rgb); end
        reset = 1'b1; step();
        checks++; if (state !== S_IDLE || rgb !== 24'h0 || play_enable !== 1'b0 || lives !== 3'd3 || win !== 1'b0) begin
            errors++; $display("FAIL reset_mid_over: state=%0d rgb=%h pe=%b lives=%0d win=%b, expected 0 000000 0 3 0", state, rgb, play_enable, lives, win);
        end
        reset = 1'b0; step();
        press_start();
        frame();
        checks++; if (state !== S_SERVE) begin errors++; $display("FAIL serve_pre_reset: state=%0d, expected 1", state); end
        reset = 1'b1; step();
        checks++; if (state !== S_IDLE || play_enable !== 1'b0) begin
            errors++; $display("FAIL reset_mid_serve: state=%0d pe=%b, expected 0 0", state, play_enable);
        end
        reset = 1'b0; step();
        press_start();
        frame();
        checks++; if (state !== S_SERVE) begin errors++; $display("FAIL serve_count_cleared: state=%0d, expected 1", state); end
        frame();
        checks++; if (state !== S_PLAY) begin errors++; $display("FAIL serve_after_reset: state=%0d, expected 2", state); end
    endtask

    // Per-cycle scoreboard: pixel k is driven with the layer data of pixel k-1.
    task automatic test_layer_play();
        logic [9:0]  nx, ny, px, py;
        logic [23:0] ng, no, pg, po, e;
        logic        nga, noa, pga, poa;
        exp_q.delete();
        px = 10'd100; py = 10'd100; pg = 24'h0; po = 24'h0; pga = 1'b0; poa = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if (rgb !== e) begin errors++; $display("FAIL layer_play_%0d: got %h, expected %h", i, rgb, e); end
            end
            if (i > 0) begin
                game_rgb = pg; game_active = pga; over_rgb = po; over_active = poa;
                exp_q.push_back(((px >= 10'd640) || (py >= 10'd480)) ? 24'h0 : (pga ? pg : 24'h0));
            end
            case (i % 4)
                0: begin nx = 10'd100; ny = 10'd100; ng = 24'h123456; no = 24'hFFFFFF; nga = 1'b1; noa = 1'b1; end
                1: begin nx = 10'd700; ny = 10'd100; ng = 24'h123456; no = 24'hFFFFFF; nga = 1'b1; noa = 1'b1; end
                default: begin
                    nx = 10'($urandom_range(0, 1023)); ny = 10'($urandom_range(0, 600));
                    if (nx == 10'd0 && ny == 10'd480) ny = 10'd0;
                    ng = 24'($urandom); no = 24'($urandom);
                    nga = 1'($urandom_range(0, 1)); noa = 1'($urandom_range(0, 1));
                end
            endcase
            pixel_x = nx; pixel_y = ny;
            px = nx; py = ny; pg = ng; po = no; pga = nga; poa = noa;
            step();
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (rgb !== e) begin errors++; $display("FAIL layer_play_last: got %h, expected %h", rgb, e); end
        end
        checks++; if (state !== S_PLAY) begin errors++; $display("FAIL layer_play_state: got %0d, expected 2", state); end
    endtask

    initial begin
        reset = 1'b1; pixel_x = 10'd100; pixel_y = 10'd100;
        start_btn = 1'b0; ball_lost = 1'b0; bricks_cleared = 1'b0;
        game_rgb = 24'h0; over_rgb = 24'h0; game_active = 1'b0; over_active = 1'b0;
        test_reset();
        test_start_held();
        test_ball_lost();
        test_over_restart();
        test_both_pulses();
        test_blink();
        test_reset_mid();
        test_layer_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
